// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP; the result returns on a valid/ready channel.
`ifndef DMEM_DATA_WIDTH
`define DMEM_DATA_WIDTH 32
`endif

module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = `DMEM_DATA_WIDTH,
  parameter int unsigned FUNC_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [FUNC_WIDTH-1:0] req0_func,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [FUNC_WIDTH-1:0] req1_func,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_z,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [FUNC_WIDTH-1:0] alu_func,
  output logic                  alu_enable,
  input  logic [DATA_WIDTH-1:0] alu_z,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] resp_z_q, resp_z_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [FUNC_WIDTH-1:0] alu_func_q, alu_func_d;
  logic                  gnt;
  logic                  gnt_any;

  // Winner selection: the round-robin pointer only matters when both requesters are valid.
  always_comb begin
    gnt     = 1'b0;
    gnt_any = 1'b0;
    case (req_valid)
      2'b01:   begin gnt = 1'b0; gnt_any = 1'b1; end
      2'b10:   begin gnt = 1'b1; gnt_any = 1'b1; end
      2'b11:   begin gnt = rr_q; gnt_any = 1'b1; end
      default: begin gnt = 1'b0; gnt_any = 1'b0; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    resp_z_d   = resp_z_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    req_ready  = '0;
    resp_valid = '0;
    alu_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready[gnt] = 1'b1;
          owner_d        = gnt;
          state_d        = EXEC;
          if (gnt) begin
            alu_a_d    = req1_a;
            alu_b_d    = req1_b;
            alu_func_d = req1_func;
          end else begin
            alu_a_d    = req0_a;
            alu_b_d    = req0_b;
            alu_func_d = req0_func;
          end
        end
      end
      EXEC: begin
        alu_enable = 1'b1;
        resp_z_d   = alu_z;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      resp_z_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      resp_z_q   <= resp_z_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
    end
  end

  assign resp_z   = resp_z_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU model closes the loop,
// expected results go into a scoreboard queue and a negedge monitor pops them on each handshake.
module tb_alu_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 3;

  localparam logic [FW-1:0] F_ADD = 3'd0;
  localparam logic [FW-1:0] F_SUB = 3'd1;
  localparam logic [FW-1:0] F_AND = 3'd2;
  localparam logic [FW-1:0] F_OR  = 3'd3;
  localparam logic [FW-1:0] F_XOR = 3'd4;
  localparam logic [FW-1:0] F_NOT = 3'd5;
  localparam logic [FW-1:0] F_LSH = 3'd6;
  localparam logic [FW-1:0] F_RSH = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FW-1:0] req0_func, req1_func;
  logic [DW-1:0] resp_z, alu_a, alu_b, alu_z;
  logic [FW-1:0] alu_func;
  logic          alu_enable, busy;

  typedef struct {
    logic          owner;
    logic [DW-1:0] z;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .FUNC_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_enable(alu_enable), .alu_z(alu_z), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU
  always_comb begin
    case (alu_func)
      F_ADD:   alu_z = alu_a + alu_b;
      F_SUB:   alu_z = alu_a - alu_b;
      F_AND:   alu_z = alu_a & alu_b;
      F_OR:    alu_z = alu_a | alu_b;
      F_XOR:   alu_z = alu_a ^ alu_b;
      F_NOT:   alu_z = ~alu_a;
      F_LSH:   alu_z = alu_a << alu_b[4:0];
      default: alu_z = alu_a >> alu_b[4:0];
    endcase
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic owner, input logic [DW-1:0] z);
    exp_t e;
    e.owner = owner;
    e.z     = z;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Single-requester operation with resp_ready high; ends back in IDLE.
  task automatic do_op(input logic r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [FW-1:0] f, input logic [DW-1:0] z, input string name);
    resp_ready = 2'b11;
    if (r) begin req1_a = a; req1_b = b; req1_func = f; req_valid = 2'b10; end
    else   begin req0_a = a; req0_b = b; req0_func = f; req_valid = 2'b01; end
    #1;
    chk({name, " grant"}, DW'(req_ready), r ? 32'd2 : 32'd1);
    push(r, z);
    tick();
    req_valid = 2'b00;
    chk({name, " func"}, DW'(alu_func), DW'(f));
    tick();
    tick();
  endtask

  // Monitor: one scoreboard comparison per response handshake
  always @(negedge clk) begin
    if (rst_n && resp_valid != 2'b00) begin
      if (resp_valid != 2'b01 && resp_valid != 2'b10) begin
        checks++;
        errors++;
        $display("FAIL resp_valid_onehot: got %b, expected one-hot", resp_valid);
      end else if ((resp_valid & resp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got valid=%b z=0x%0h, expected none", resp_valid, resp_z);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb owner", DW'(resp_valid), e.owner ? 32'd2 : 32'd1);
          chk("sb resp_z", resp_z, e.z);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; resp_ready = '0;
    req0_a = '0; req0_b = '0; req0_func = '0;
    req1_a = '0; req1_b = '0; req1_func = '0;
    tick();
    chk("reset busy", DW'(busy), 0);
    chk("reset resp_valid", DW'(resp_valid), 0);
    chk("reset alu_enable", DW'(alu_enable), 0);
    chk("reset resp_z", resp_z, 0);
    chk("reset alu_a", alu_a, 0);
    tick();
    rst_n = 1'b1;

    // 1: single ADD, latency check
    req0_a = 5; req0_b = 3; req0_func = F_ADD; req_valid = 2'b01; resp_ready = 2'b11;
    #1;
    chk("t1 req_ready", DW'(req_ready), 1);
    push(1'b0, 8);
    tick();
    req_valid = 2'b00;
    chk("t1 alu_enable", DW'(alu_enable), 1);
    chk("t1 exec req_ready", DW'(req_ready), 0);
    chk("t1 alu_a", alu_a, 5);
    chk("t1 alu_b", alu_b, 3);
    tick();
    chk("t1 resp_valid", DW'(resp_valid), 1);
    chk("t1 resp_z", resp_z, 8);
    chk("t1 resp alu_enable", DW'(alu_enable), 0);
    tick();
    chk("t1 busy", DW'(busy), 0);

    // 2: both valid from reset, round-robin over three rounds
    do_reset();
    req0_a = 10;    req0_b = 4;    req0_func = F_SUB;
    req1_a = 'hF0;  req1_b = 'hFF; req1_func = F_XOR;
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int unsigned r = 0; r < 3; r++) begin
      #1;
      chk($sformatf("t2 grant round %0d", r), DW'(req_ready), (r == 1) ? 32'd2 : 32'd1);
      if (r == 1) push(1'b1, 'h0F);
      else        push(1'b0, 6);
      tick();
      if (r == 2) req_valid = 2'b00;
      tick();
      tick();
    end

    // 3: backpressure on requester 1, requester 0 waiting
    req1_a = 'hC; req1_b = 'hA; req1_func = F_AND;
    req0_a = 1;   req0_b = 2;   req0_func = F_OR;
    req_valid = 2'b10; resp_ready = 2'b00;
    #1;
    chk("t3 grant", DW'(req_ready), 2);
    push(1'b1, 8);
    tick();
    req_valid = 2'b11;
    tick();
    for (int unsigned c = 0; c < 5; c++) begin
      chk("t3 held resp_valid", DW'(resp_valid), 2);
      chk("t3 held resp_z", resp_z, 8);
      chk("t3 held req_ready", DW'(req_ready), 0);
      tick();
    end
    resp_ready = 2'b10;
    tick();
    chk("t3 next grant", DW'(req_ready), 1);
    push(1'b0, 3);
    tick();
    req_valid = 2'b00;

    // 4: ready from the wrong requester is ignored
    tick();
    for (int unsigned c = 0; c < 3; c++) begin
      chk("t4 resp_valid", DW'(resp_valid), 1);
      chk("t4 busy", DW'(busy), 1);
      tick();
    end
    resp_ready = 2'b01;
    tick();
    chk("t4 idle busy", DW'(busy), 0);

    // 5: reset asserted during EXEC discards the operation
    req0_a = 1; req0_b = 1; req0_func = F_ADD; req_valid = 2'b01; resp_ready = 2'b11;
    tick();
    chk("t5 exec alu_enable", DW'(alu_enable), 1);
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("t5 rst alu_enable", DW'(alu_enable), 0);
    chk("t5 rst busy", DW'(busy), 0);
    chk("t5 rst resp_valid", DW'(resp_valid), 0);
    chk("t5 rst alu_a", alu_a, 0);
    chk("t5 rst alu_func", DW'(alu_func), 0);
    tick();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      chk("t5 post resp_valid", DW'(resp_valid), 0);
      chk("t5 post busy", DW'(busy), 0);
    end

    // 6: wrap / shift / not, plus the remaining func codes on requester 1
    do_op(1'b0, '1, 1, F_ADD, 0, "t6 add wrap");
    do_op(1'b0, 'h80, 3, F_RSH, 'h10, "t6 rsh");
    do_op(1'b0, 0, 0, F_NOT, '1, "t6 not");
    do_op(1'b1, 3, 4, F_LSH, 'h30, "t6 lsh");
    do_op(1'b1, 2, 5, F_SUB, 32'hFFFF_FFFD, "t6 sub wrap");

    for (int unsigned i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard drained", DW'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single ALU instance between two requesters (e.g. the execute stage and the address-generation path) using round-robin arbitration. It sequences each operation through a fixed IDLE -> EXEC -> RESP flow and drives the ALU operand, func and enable inputs. It captures the ALU z output into a registered result, which is returned to the winning requester over a valid/ready response channel. It sits between the requesters and the ALU; the ALU itself is instantiated alongside it, not inside it.

Parameters:
DATA_WIDTH, `DMEM_DATA_WIDTH, operand/result width; must match the ALU.
FUNC_WIDTH, 3, ALU function code width (ALU_FUNC_* encodings).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  2  per-requester request valid; bit i = requester i.
req_ready  out  2  per-requester accept; one-hot or zero.
req0_a, req0_b  in  DATA_WIDTH  requester 0 operands.
req0_func  in  FUNC_WIDTH  requester 0 ALU function.
req1_a, req1_b  in  DATA_WIDTH  requester 1 operands.
req1_func  in  FUNC_WIDTH  requester 1 ALU function.
resp_valid  out  2  per-requester result valid; one-hot or zero.
resp_ready  in  2  per-requester result accept.
resp_z  out  DATA_WIDTH  registered result; shared bus, qualified by resp_valid.
alu_a, alu_b  out  DATA_WIDTH  to ALU a/b.
alu_func  out  FUNC_WIDTH  to ALU func.
alu_enable  out  1  to ALU enable.
alu_z  in  DATA_WIDTH  from ALU z.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; rr_ptr = 0 (requester 0 preferred).
  - resp_z, alu_a, alu_b, alu_func = 0.
  - alu_enable, resp_valid, busy = 0.
  - Any in-flight operation is discarded; no response is produced after reset releases.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. When both request bits are valid, it grants requester rr_ptr. When one bit is valid, it grants that requester. Otherwise it is 0.
  - A transfer occurs when req_valid[i] && req_ready[i] in the same cycle.
  - On a transfer: latch that requester's a/b/func into alu_a/alu_b/alu_func; record owner = i; go to EXEC.
  - No transfer: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_enable = 1 (combinational decode of state); req_ready = 0.
  - At the clock edge: resp_z <= alu_z; go to RESP.
- RESP:
  - alu_enable = 0; resp_valid[owner] = 1; req_ready = 0.
  - When resp_ready[owner] = 1: go to IDLE and set rr_ptr = ~owner.
  - Otherwise hold. resp_z, owner and the alu_* operands stay stable while held.
  - resp_ready of the non-owner is ignored.
- alu_a/alu_b/alu_func hold their last latched values outside EXEC.
- Latency: transfer at cycle T -> resp_valid at T+2. Minimum issue interval is 3 cycles (back-to-back with resp_ready tied high).
- Fairness:
  - rr_ptr changes only on response completion.
  - A requester holding req_valid continuously is granted within one operation of the other requester.
- req_valid dropped before transfer: nothing is latched; there is no obligation to hold.
- Arithmetic: the block applies no arithmetic. resp_z is exactly alu_z, DATA_WIDTH bits, with whatever wrap/truncation the ALU applies.
- All 8 func codes are passed through unchanged.
- busy = (state != IDLE).

Test Plan:
1. Reset released, req_valid=2'b01, req0 a=5, b=3, func=ALU_FUNC_ADD, resp_ready=2'b11 -> req_ready=01 at T; alu_enable=1 at T+1; resp_valid=01 with resp_z=8 at T+2; busy=0 at T+3.
2. Both valid from reset: req0 SUB 10,4; req1 XOR 0xF0,0xFF; resp_ready=11 -> requester 0 served first (resp_z=6). Requester 1 is granted next (resp_z=0x0F). A third round with both still valid grants requester 0.
3. Backpressure: req1 AND 0xC,0xA with resp_ready=00 for 5 cycles -> resp_valid=10 and resp_z=8 held stable; req_ready=00 although req_valid[0]=1. Raising resp_ready[1] returns the FSM to IDLE, and requester 0 is granted the next cycle.
4. Wrong-owner ready: owner=0, resp_ready=10 -> FSM stays in RESP; resp_valid remains 01.
5. Reset mid-operation: assert rst_n low while in EXEC -> all outputs are 0 immediately. After release with no requests, resp_valid stays 00 and busy=0.
6. Wrap: req0 ADD all-ones + 1 -> resp_z=0. Then req0 RSH 0x80,3 -> resp_z=0x10. Then NOT 0 -> resp_z=all-ones.
